sprite_line_scheduler: RTL and testbench

Per-scanline sprite evaluation and fetch sequencer for the PPU. On each line-start pulse it scans OAM for sprites that intersect the requested line and keeps the first MAX_SPRITES hits in OAM order. It then fetches each selected sprite's pattern row from sprite graphics memory and loads the sprite shift-register slots with pattern, X position and palette. It owns the PPU-side read ports of OAM and sprite graphics and never writes either memory.

---
 rtl/sprite_line_scheduler.sv | 141 ++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluation and pattern fetch sequencer.
// Scans OAM for sprites on the target line, then loads the sprite shift-register slots.
module sprite_line_scheduler #(
    parameter int unsigned NUM_OAM     = 64,
    parameter int unsigned MAX_SPRITES = 8,
    parameter int unsigned SPRITE_H    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [9:0]  target_line,
    output logic [7:0]  oam_addr,
    input  logic [31:0] oam_rdata,
    output logic [10:0] sg_addr,
    input  logic [31:0] sg_rdata,
    output logic        slot_we,
    output logic [2:0]  slot_idx,
    output logic [31:0] slot_pattern,
    output logic [9:0]  slot_x,
    output logic        slot_palette,
    output logic [3:0]  sprite_count,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SEL_W = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, FETCH, DONE} state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [6:0] tile;
        logic [3:0] row;
        logic       pal;
    } sel_t;

    state_t      state, state_nx;
    logic [8:0]  cnt;
    logic [9:0]  line_q;
    logic [3:0]  count_q;
    logic        ovf_q;
    sel_t        sel_q [MAX_SPRITES];
    logic [10:0] diff;
    logic        hit;
    logic [3:0]  fetch_j;
    logic        unused_rsv;

    assign unused_rsv = ^oam_rdata[3:1];

    // 11-bit subtraction: a borrow into bit 10 means y is below the line, never a wrap-around hit.
    always_comb begin
        diff = {1'b0, line_q} - {1'b0, oam_rdata[31:22]};
        hit  = oam_rdata[0] && !diff[10] && (diff < 11'(SPRITE_H));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (line_start) state_nx = EVAL;
            EVAL:    if (line_start) state_nx = EVAL;
                     else if (cnt == 9'(NUM_OAM)) state_nx = FETCH;
            FETCH:   if (line_start) state_nx = EVAL;
                     else if (cnt == 9'(MAX_SPRITES)) state_nx = DONE;
            DONE:    state_nx = line_start ? EVAL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cnt is the OAM address during EVAL (entry cnt-1 is judged) and the fetch index during FETCH.
    always_ff @(posedge clk) begin
        if (reset || line_start) begin
            cnt     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            line_q  <= reset ? '0 : target_line;
            for (int unsigned i = 0; i < MAX_SPRITES; i++) sel_q[i] <= '0;
        end else begin
            unique case (state)
                EVAL: begin
                    cnt <= (cnt == 9'(NUM_OAM)) ? '0 : cnt + 9'd1;
                    if (cnt != '0 && hit) begin
                        if (count_q < 4'(MAX_SPRITES)) begin
                            sel_q[count_q[SEL_W-1:0]] <= {oam_rdata[21:12], oam_rdata[11:5],
                                                          diff[3:0], oam_rdata[4]};
                            count_q <= count_q + 4'd1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                FETCH:   cnt <= cnt + 9'd1;
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        oam_addr     = '0;
        sg_addr      = '0;
        slot_we      = 1'b0;
        slot_idx     = '0;
        slot_pattern = '0;
        slot_x       = '0;
        slot_palette = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        sprite_count = count_q;
        overflow     = ovf_q;
        fetch_j      = cnt[3:0] - 4'd1;
        unique case (state)
            EVAL: begin
                busy = 1'b1;
                if (cnt < 9'(NUM_OAM)) oam_addr = cnt[7:0];
            end
            FETCH: begin
                busy = 1'b1;
                if (cnt < 9'(MAX_SPRITES) && cnt < {5'b0, count_q})
                    sg_addr = {sel_q[cnt[SEL_W-1:0]].tile, sel_q[cnt[SEL_W-1:0]].row};
                // A restart in this cycle suppresses the load so nothing from the old line lands.
                if (cnt != '0 && !line_start) begin
                    slot_we  = 1'b1;
                    slot_idx = fetch_j[2:0];
                    if (fetch_j < count_q) begin
                        slot_pattern = sg_rdata;
                        slot_x       = sel_q[fetch_j[SEL_W-1:0]].x;
                        slot_palette = sel_q[fetch_j[SEL_W-1:0]].pal;
                    end
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized and directed bench for sprite_line_scheduler against a list-based reference model.
module tb_sprite_line_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [9:0]  target_line;
    logic [7:0]  oam_addr;
    logic [31:0] oam_rdata;
    logic [10:0] sg_addr;
    logic [31:0] sg_rdata;
    logic        slot_we;
    logic [2:0]  slot_idx;
    logic [31:0] slot_pattern;
    logic [9:0]  slot_x;
    logic        slot_palette;
    logic [3:0]  sprite_count;
    logic        overflow;
    logic        busy;
    logic        done;

    sprite_line_scheduler #(.NUM_OAM(64), .MAX_SPRITES(8), .SPRITE_H(16)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .target_line(target_line),
        .oam_addr(oam_addr), .oam_rdata(oam_rdata), .sg_addr(sg_addr), .sg_rdata(sg_rdata),
        .slot_we(slot_we), .slot_idx(slot_idx), .slot_pattern(slot_pattern), .slot_x(slot_x),
        .slot_palette(slot_palette), .sprite_count(sprite_count), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] oam_mem [64];
    logic [31:0] sg_mem  [2048];

    always @(posedge clk) begin
        oam_rdata <= (oam_addr < 8'd64) ? oam_mem[oam_addr[5:0]] : 32'h0;
        sg_rdata  <= sg_mem[sg_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] pat;
        int          x;
        int          pal;
    } ev_t;

    ev_t  evq[$];
    logic mon_en = 1'b0;
    int   start_cyc = 0;
    int   rel_m;
    int   done_n, done_rel, cnt_done, ovf_done;
    int   oam_a1, oam_a41, busy1;
    int   sg_seen [8];

    always @(negedge clk) begin
        if (mon_en) begin
            rel_m = cyc - start_cyc;
            if (slot_we) evq.push_back('{int'(slot_idx), slot_pattern, int'(slot_x), int'(slot_palette)});
            if (done) begin
                done_n++;
                done_rel = rel_m;
                cnt_done = int'(sprite_count);
                ovf_done = int'(overflow);
            end
            if (rel_m == 1) begin
                oam_a1 = int'(oam_addr);
                busy1  = int'(busy);
            end
            if (rel_m == 41) oam_a41 = int'(oam_addr);
            if (rel_m >= 66 && rel_m < 74) sg_seen[rel_m-66] = int'(sg_addr);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int y, input int x, input int tile, input int pal, input int en);
        return {10'(y), 10'(x), 7'(tile), 1'(pal), 3'b000, 1'(en)};
    endfunction

    logic [31:0] exp_pat [8];
    int          exp_x [8], exp_pal [8], exp_sg [8];
    int          exp_cnt, exp_ovf;

    // Reference: list every hitting entry in OAM order, keep the first eight.
    task automatic build_expected(input int line);
        int hits[$];
        for (int i = 0; i < 64; i++) begin
            int y;
            y = int'(oam_mem[i][31:22]);
            if (oam_mem[i][0] && line >= y && line - y < 16) hits.push_back(i);
        end
        exp_cnt = (hits.size() > 8) ? 8 : hits.size();
        exp_ovf = (hits.size() > 8) ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            if (k < exp_cnt) begin
                logic [31:0] e;
                e          = oam_mem[hits[k]];
                exp_sg[k]  = int'(e[11:5]) * 16 + (line - int'(e[31:22]));
                exp_pat[k] = sg_mem[exp_sg[k]];
                exp_x[k]   = int'(e[21:12]);
                exp_pal[k] = int'(e[4]);
            end else begin
                exp_sg[k]  = 0;
                exp_pat[k] = 32'h0;
                exp_x[k]   = 0;
                exp_pal[k] = 0;
            end
        end
    endtask

    task automatic clear_mon();
        evq.delete();
        done_n = 0; done_rel = -1; cnt_done = -1; ovf_done = -1;
        oam_a1 = -1; oam_a41 = -1; busy1 = -1;
        for (int k = 0; k < 8; k++) sg_seen[k] = -1;
        mon_en = 1'b1;
    endtask

    task automatic start_line(input int line);
        @(posedge clk); #1;
        target_line = 10'(line);
        line_start  = 1'b1;
        start_cyc   = cyc;
        @(posedge clk); #1;
        line_start  = 1'b0;
    endtask

    task automatic finish_and_check(input string tag, input int line);
        int t;
        build_expected(line);
        t = 0;
        while (done_n == 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_done_seen"}, (done_n != 0) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, done_n, 1);
        check({tag, "_done_lat"}, done_rel, 75);
        check({tag, "_count"}, cnt_done, exp_cnt);
        check({tag, "_ovf"}, ovf_done, exp_ovf);
        check({tag, "_oam0"}, oam_a1, 0);
        check({tag, "_oam40"}, oam_a41, 40);
        check({tag, "_busy"}, busy1, 1);
        check({tag, "_nslots"}, evq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_sg%0d", tag, k), sg_seen[k], exp_sg[k]);
            if (k < evq.size()) begin
                check($sformatf("%s_idx%0d", tag, k), evq[k].idx, k);
                check($sformatf("%s_pat%0d", tag, k), evq[k].pat, exp_pat[k]);
                check($sformatf("%s_x%0d", tag, k), evq[k].x, exp_x[k]);
                check($sformatf("%s_pal%0d", tag, k), evq[k].pal, exp_pal[k]);
            end
        end
        check({tag, "_hold_cnt"}, sprite_count, exp_cnt);
        check({tag, "_hold_ovf"}, overflow, exp_ovf);
        check({tag, "_idle"}, {busy, done, slot_we}, 3'b000);
        mon_en = 1'b0;
    endtask

    task automatic run_line(input string tag, input int line);
        clear_mon();
        start_line(line);
        finish_and_check(tag, line);
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 64; i++) oam_mem[i] = 32'h0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; line_start = 1'b0; target_line = '0;
        clear_oam();
        for (int i = 0; i < 2048; i++) sg_mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        line_start = 1'b1;
        target_line = 10'd7;
        @(posedge clk); #1;
        reset = 1'b0; line_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {slot_we, busy, done, overflow, slot_palette}, 5'b0);
        check("rst_count", sprite_count, 4'd0);
        check("rst_addr", {oam_addr, sg_addr}, 19'd0);
        check("rst_slot", {slot_idx, slot_x}, 13'd0);
        check("rst_pat", slot_pattern, 32'h0);

        oam_mem[5] = mk(100, 200, 3, 1, 1);
        run_line("t2", 107);
        check("t2_sg0", sg_seen[0], 32'h37);

        run_line("t3_row0", 100);
        run_line("t3_row15", 115);
        run_line("t3_116", 116);
        run_line("t3_99", 99);
        oam_mem[5] = mk(100, 200, 3, 1, 0);
        run_line("t3_dis", 100);

        clear_oam();
        for (int i = 0; i < 10; i++)
            oam_mem[i] = mk(40 + i, $urandom_range(0, 1023), $urandom_range(0, 127), i % 2, 1);
        run_line("t4", 50);

        clear_oam();
        oam_mem[0] = mk(1020, 33, 9, 1, 1);
        run_line("t5", 5);

        clear_oam();
        for (int i = 0; i < 64; i++)
            oam_mem[i] = mk($urandom_range(10, 35), $urandom_range(0, 1023),
                            $urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
        clear_mon();
        start_line(20);
        repeat (28) @(posedge clk);
        start_line(30);
        finish_and_check("t6", 30);

        for (int r = 0; r < 8; r++) begin
            int line;
            line = $urandom_range(0, 1023);
            for (int i = 0; i < 64; i++)
                oam_mem[i] = mk((line + 1024 + 6 - $urandom_range(0, 30)) % 1024,
                                $urandom_range(0, 1023), $urandom_range(0, 127),
                                $urandom_range(0, 1), $urandom_range(0, 3) != 0)
                             | ($urandom & 32'hE);
            run_line($sformatf("rnd%0d", r), line);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
